// File: rtl/lighthouse_sensor_conditioner.sv
// Photodiode front end: synchronize and deglitch each sensor, measure high-pulse
// widths, and serialize the width records through a round-robin output register.
module lighthouse_sensor_lane #(
  parameter int FILTER_LEN = 4,
  parameter int WIDTH_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  raw,
  input  logic                  load,
  output logic                  clean,
  output logic                  pend,
  output logic                  ovf,
  output logic [WIDTH_BITS-1:0] pend_width
);
  logic                  sync1, sync2, clean_d, fall;
  logic [3:0]            stable_cnt;
  logic [WIDTH_BITS-1:0] width_cnt;

  assign fall = clean_d & ~clean;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      stable_cnt <= '0;
      clean      <= 1'b0;
      clean_d    <= 1'b0;
      width_cnt  <= '0;
      pend       <= 1'b0;
      ovf        <= 1'b0;
      pend_width <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      clean_d <= clean;
      // Level flips only after FILTER_LEN consecutive disagreeing samples.
      if (stable_cnt == 4'(FILTER_LEN)) begin
        clean      <= ~clean;
        stable_cnt <= '0;
      end else if (sync2 != clean) begin
        stable_cnt <= stable_cnt + 4'd1;
      end else begin
        stable_cnt <= '0;
      end
      if (!clean)
        width_cnt <= '0;
      else if (width_cnt != '1)
        width_cnt <= width_cnt + 1'b1;
      // A fresh capture beats a same-cycle load; overwriting an unsent width is sticky.
      if (fall) begin
        pend_width <= width_cnt;
        pend       <= 1'b1;
        ovf        <= load ? 1'b0 : (ovf | pend);
      end else if (load) begin
        pend <= 1'b0;
        ovf  <= 1'b0;
      end
    end
  end
endmodule

module lighthouse_sensor_conditioner #(
  parameter int NUM_SENSORS = 32,
  parameter int FILTER_LEN  = 4,
  parameter int WIDTH_BITS  = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_SENSORS-1:0] sensor_raw,
  output logic [NUM_SENSORS-1:0] sensor_clean,
  output logic                   event_valid,
  input  logic                   event_ready,
  output logic [4:0]             event_channel,
  output logic [WIDTH_BITS-1:0]  event_width,
  output logic                   event_overflow
);
  logic [NUM_SENSORS-1:0]                 pend, ovf;
  logic [NUM_SENSORS-1:0][WIDTH_BITS-1:0] pend_width;
  logic [4:0]                             last, grant, lo, hi;
  logic                                   any_pend, hi_found, load, sel_ovf;
  logic [WIDTH_BITS-1:0]                  sel_width;

  for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_lane
    lighthouse_sensor_lane #(.FILTER_LEN(FILTER_LEN), .WIDTH_BITS(WIDTH_BITS)) u_lane (
      .clk        (clk),
      .reset_n    (reset_n),
      .raw        (sensor_raw[i]),
      .load       (load && (grant == 5'(i))),
      .clean      (sensor_clean[i]),
      .pend       (pend[i]),
      .ovf        (ovf[i]),
      .pend_width (pend_width[i])
    );
  end

  // Round robin: lowest pending index above last grant, else lowest overall.
  always_comb begin
    lo        = '0;
    hi        = '0;
    any_pend  = 1'b0;
    hi_found  = 1'b0;
    sel_width = '0;
    sel_ovf   = 1'b0;
    for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
      if (pend[i]) begin
        lo       = 5'(i);
        any_pend = 1'b1;
        if (5'(i) > last) begin
          hi       = 5'(i);
          hi_found = 1'b1;
        end
      end
    end
    grant = hi_found ? hi : lo;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      if (5'(i) == grant) begin
        sel_width = pend_width[i];
        sel_ovf   = ovf[i];
      end
    end
  end

  assign load = any_pend && (!event_valid || event_ready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last           <= 5'(NUM_SENSORS - 1);
      event_valid    <= 1'b0;
      event_channel  <= '0;
      event_width    <= '0;
      event_overflow <= 1'b0;
    end else if (load) begin
      last           <= grant;
      event_valid    <= 1'b1;
      event_channel  <= grant;
      event_width    <= sel_width;
      event_overflow <= sel_ovf;
    end else if (event_ready) begin
      event_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_lighthouse_sensor_conditioner.sv
// Directed bench: inputs change and outputs are sampled on the falling clock edge.
module tb_lighthouse_sensor_conditioner;
  localparam int N  = 32;
  localparam int WB = 16;

  logic          clk, reset_n, event_valid, event_ready, event_overflow;
  logic [N-1:0]  sensor_raw, sensor_clean;
  logic [4:0]    event_channel;
  logic [WB-1:0] event_width;
  int checks = 0;
  int errors = 0;

  lighthouse_sensor_conditioner #(.NUM_SENSORS(N), .FILTER_LEN(4), .WIDTH_BITS(WB)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .sensor_raw     (sensor_raw),
    .sensor_clean   (sensor_clean),
    .event_valid    (event_valid),
    .event_ready    (event_ready),
    .event_channel  (event_channel),
    .event_width    (event_width),
    .event_overflow (event_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_event(input string tag, input int ch, input int w, input int ov);
    chk({tag, "_valid"}, 32'(event_valid), 1);
    chk({tag, "_chan"}, 32'(event_channel), 32'(ch));
    chk({tag, "_width"}, 32'(event_width), 32'(w));
    chk({tag, "_ovf"}, 32'(event_overflow), 32'(ov));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_clean"}, sensor_clean, 0);
    chk({tag, "_valid"}, 32'(event_valid), 0);
    chk({tag, "_chan"}, 32'(event_channel), 0);
    chk({tag, "_width"}, 32'(event_width), 0);
    chk({tag, "_ovf"}, 32'(event_overflow), 0);
  endtask

  task automatic wait_valid(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (!event_valid && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_arrived"}, 32'(event_valid), 1);
  endtask

  // Pulse whose record is expected to stay queued (ready held low).
  task automatic pulse(input int ch, input int w);
    sensor_raw[ch] = 1'b1;
    tick(w);
    sensor_raw[ch] = 1'b0;
    tick(15);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sensor_raw = '0;
    tick(3);
    reset_n = 1'b1;
    tick(2);
  endtask

  initial begin
    logic seen;
    reset_n     = 1'b0;
    sensor_raw  = '0;
    event_ready = 1'b1;
    tick(3);
    chk_zero("reset");
    reset_n = 1'b1;
    tick(2);

    // Channel 3, 100-cycle pulse: clean rises 6 cycles after first sample, record 2 cycles after fall.
    sensor_raw[3] = 1'b1;
    tick(6);
    chk("clean3_before", 32'(sensor_clean[3]), 0);
    tick(1);
    chk("clean3_rise", 32'(sensor_clean[3]), 1);
    tick(93);
    sensor_raw[3] = 1'b0;
    tick(8);
    chk("ch3_not_yet", 32'(event_valid), 0);
    tick(1);
    chk_event("ch3", 3, 100, 0);
    tick(1);
    chk("ch3_accepted", 32'(event_valid), 0);

    // Three-cycle glitch on channel 0 must be filtered out completely.
    sensor_raw[0] = 1'b1;
    tick(3);
    sensor_raw[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      seen = seen | sensor_clean[0] | event_valid;
    end
    chk("glitch_filtered", 32'(seen), 0);

    // Simultaneous falls on 5, 1, 9 after reset: round robin from index 0.
    do_reset();
    sensor_raw[1] = 1'b1;
    sensor_raw[5] = 1'b1;
    sensor_raw[9] = 1'b1;
    tick(10);
    sensor_raw = '0;
    tick(8);
    chk("rr_not_yet", 32'(event_valid), 0);
    tick(1);
    chk_event("rr_first", 1, 10, 0);
    tick(1);
    chk_event("rr_second", 5, 10, 0);
    tick(1);
    chk_event("rr_third", 9, 10, 0);
    tick(1);
    chk("rr_drained", 32'(event_valid), 0);

    // Back-pressure on channel 7: 20 is held; 25 is queued then overwritten by 30.
    event_ready = 1'b0;
    pulse(7, 20);
    chk_event("hold20", 7, 20, 0);
    pulse(7, 25);
    pulse(7, 30);
    chk_event("hold20_still", 7, 20, 0);
    event_ready = 1'b1;
    tick(1);
    chk_event("overwrite30", 7, 30, 1);
    tick(1);
    chk("overwrite_drained", 32'(event_valid), 0);
    sensor_raw[7] = 1'b1;
    tick(40);
    sensor_raw[7] = 1'b0;
    wait_valid("after_ovf", 20);
    chk_event("after_ovf", 7, 40, 0);

    // Saturation: 70000-cycle pulse on channel 2.
    tick(5);
    sensor_raw[2] = 1'b1;
    tick(70000);
    sensor_raw[2] = 1'b0;
    wait_valid("sat", 20);
    chk_event("sat", 2, 65535, 0);

    // Reset with a held record and channel 4 mid-pulse discards everything.
    tick(5);
    event_ready = 1'b0;
    pulse(6, 5);
    chk("pre_reset_valid", 32'(event_valid), 1);
    sensor_raw[4] = 1'b1;
    tick(30);
    chk("pre_reset_clean4", 32'(sensor_clean[4]), 1);
    reset_n = 1'b0;
    sensor_raw = '0;
    #1;
    chk_zero("mid_reset");
    tick(2);
    reset_n = 1'b1;
    event_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      seen = seen | event_valid | (|sensor_clean);
    end
    chk("no_stale_event", 32'(seen), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
